// File: rtl/mem_types_pkg.sv
// Shared dcache/memory types: geometry, MOESI encoding, snoop request record and
// the snoop-induced MOESI transition.
package mem_types_pkg;

  localparam int BLOCK_ADDR_SPACE_WIDTH   = 26;
  localparam int DCACHE_NUM_INDEX_BITS    = 6;
  localparam int DCACHE_NUM_TAG_BITS      = BLOCK_ADDR_SPACE_WIDTH - DCACHE_NUM_INDEX_BITS;
  localparam int DCACHE_NUM_WAYS          = 4;
  localparam int DCACHE_LOG_NUM_WAYS      = 2;
  localparam int DCACHE_SNOOP_REQ_Q_DEPTH = 4;

  typedef struct packed {
    logic valid;
    logic exclusive;
    logic dirty;
  } MOESI_state_t;

  localparam MOESI_state_t MOESI_I = 3'b000;
  localparam MOESI_state_t MOESI_S = 3'b100;
  localparam MOESI_state_t MOESI_E = 3'b110;
  localparam MOESI_state_t MOESI_O = 3'b101;
  localparam MOESI_state_t MOESI_M = 3'b111;

  typedef struct packed {
    logic [BLOCK_ADDR_SPACE_WIDTH-1:0] block_addr;
    logic                              exclusive;
  } dcache_snoop_req_t;

  typedef enum logic [1:0] {
    SNOOP_IDLE,
    SNOOP_LOOKUP,
    SNOOP_UPDATE,
    SNOOP_RESPOND
  } snoop_responder_state_t;

  // Shared snoops demote owners/exclusives; invalidating snoops kill any valid line.
  function automatic MOESI_state_t snoop_next_moesi(input MOESI_state_t cur, input logic exclusive);
    MOESI_state_t nxt;
    nxt = MOESI_I;
    if (!exclusive) begin
      case (cur)
        MOESI_M: nxt = MOESI_O;
        MOESI_O: nxt = MOESI_O;
        MOESI_E: nxt = MOESI_S;
        MOESI_S: nxt = MOESI_S;
        default: nxt = MOESI_I;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dcache_snoop_req_q.sv
// Circular FIFO of snoop requests; pointers carry an extra wrap bit so full and
// empty are told apart by the MSB. Pushes while full and pops while empty are ignored.
module dcache_snoop_req_q
  import mem_types_pkg::*;
#(
  parameter int DEPTH = DCACHE_SNOOP_REQ_Q_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  dcache_snoop_req_t push_data,
  input  logic              pop,
  output dcache_snoop_req_t head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  dcache_snoop_req_t entries [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full) entries[wr_ptr[AW-1:0]] <= push_data;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = entries[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dcache_snoop_responder.sv
// Serves bus snoops one at a time: queue, tag lookup, optional MOESI write-back, response.
// DCACHE_SNOOP_BYPASS_EN lets a request arriving to an idle, empty responder skip the queue.
module dcache_snoop_responder
  import mem_types_pkg::*;
#(
  parameter int SNOOP_Q_DEPTH = DCACHE_SNOOP_REQ_Q_DEPTH
) (
  input  logic                                                    CLK,
  input  logic                                                    RST,
  input  logic                                                    snoop_req_valid,
  input  logic [BLOCK_ADDR_SPACE_WIDTH-1:0]                       snoop_req_block_addr,
  input  logic                                                    snoop_req_exclusive,
  output logic                                                    snoop_req_ready,
  output logic                                                    tag_read_valid,
  output logic [DCACHE_NUM_INDEX_BITS-1:0]                        tag_read_index,
  input  logic                                                    tag_read_grant,
  input  logic [DCACHE_NUM_WAYS-1:0][DCACHE_NUM_TAG_BITS-1:0]     tag_read_tag_by_way,
  input  MOESI_state_t [DCACHE_NUM_WAYS-1:0]                      tag_read_state_by_way,
  output logic                                                    state_write_valid,
  output logic [DCACHE_NUM_INDEX_BITS-1:0]                        state_write_index,
  output logic [DCACHE_LOG_NUM_WAYS-1:0]                          state_write_way,
  output MOESI_state_t                                            state_write_state,
  output logic                                                    snoop_resp_valid,
  input  logic                                                    snoop_resp_ready,
  output logic                                                    snoop_resp_hit,
  output logic                                                    snoop_resp_supply,
  output logic [DCACHE_LOG_NUM_WAYS-1:0]                          snoop_resp_way,
  output logic [BLOCK_ADDR_SPACE_WIDTH-1:0]                       snoop_resp_block_addr
);

  snoop_responder_state_t state, next_state;

  dcache_snoop_req_t                work, q_head, req_in;
  logic                             q_full, q_empty, q_push, q_pop, bypass_take;
  logic [DCACHE_NUM_TAG_BITS-1:0]   work_tag;
  logic                             lk_hit;
  logic [DCACHE_LOG_NUM_WAYS-1:0]   lk_way;
  MOESI_state_t                     lk_old, lk_new;
  logic                             hit_q, supply_q;
  logic [DCACHE_LOG_NUM_WAYS-1:0]   way_q;
  MOESI_state_t                     new_q;

  assign req_in          = '{block_addr: snoop_req_block_addr, exclusive: snoop_req_exclusive};
  assign snoop_req_ready = !q_full && !RST;
  assign q_pop           = (state == SNOOP_IDLE) && !q_empty;
`ifdef DCACHE_SNOOP_BYPASS_EN
  assign bypass_take     = (state == SNOOP_IDLE) && q_empty && snoop_req_valid;
`else
  assign bypass_take     = 1'b0;
`endif
  assign q_push          = snoop_req_valid && snoop_req_ready && !bypass_take;

  dcache_snoop_req_q #(.DEPTH(SNOOP_Q_DEPTH)) u_req_q (
    .CLK       (CLK),
    .RST       (RST),
    .push      (q_push),
    .push_data (req_in),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign work_tag = work.block_addr[BLOCK_ADDR_SPACE_WIDTH-1 -: DCACHE_NUM_TAG_BITS];

  // Scan from the top way down so the lowest matching way is the one kept.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = DCACHE_NUM_WAYS - 1; w >= 0; w--) begin
      if (tag_read_state_by_way[w].valid && (tag_read_tag_by_way[w] == work_tag)) begin
        lk_hit = 1'b1;
        lk_way = DCACHE_LOG_NUM_WAYS'(w);
      end
    end
    lk_old = tag_read_state_by_way[lk_way];
    lk_new = snoop_next_moesi(lk_old, work.exclusive);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= SNOOP_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SNOOP_IDLE:    if (q_pop || bypass_take) next_state = SNOOP_LOOKUP;
      SNOOP_LOOKUP:  if (tag_read_grant)
                       next_state = (lk_hit && (lk_new != lk_old)) ? SNOOP_UPDATE : SNOOP_RESPOND;
      SNOOP_UPDATE:  next_state = SNOOP_RESPOND;
      SNOOP_RESPOND: if (snoop_resp_ready) next_state = SNOOP_IDLE;
      default:       next_state = SNOOP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      work     <= '0;
      hit_q    <= 1'b0;
      supply_q <= 1'b0;
      way_q    <= '0;
      new_q    <= MOESI_I;
    end else begin
      if (q_pop)            work <= q_head;
      else if (bypass_take) work <= req_in;
      if ((state == SNOOP_LOOKUP) && tag_read_grant) begin
        hit_q    <= lk_hit;
        supply_q <= lk_hit && lk_old.dirty;
        way_q    <= lk_way;
        new_q    <= lk_new;
      end
    end
  end

  // A reset landing in UPDATE must not let the array write through.
  always_comb begin
    tag_read_valid        = (state == SNOOP_LOOKUP);
    tag_read_index        = work.block_addr[DCACHE_NUM_INDEX_BITS-1:0];
    state_write_valid     = (state == SNOOP_UPDATE) && !RST;
    state_write_index     = work.block_addr[DCACHE_NUM_INDEX_BITS-1:0];
    state_write_way       = way_q;
    state_write_state     = new_q;
    snoop_resp_valid      = (state == SNOOP_RESPOND);
    snoop_resp_hit        = hit_q;
    snoop_resp_supply     = supply_q;
    snoop_resp_way        = way_q;
    snoop_resp_block_addr = work.block_addr;
  end

endmodule
